// File: rtl/dct_coef_engine.sv
// Sequential 2D DCT coefficient engine: one (k1,k2) request, an NxN raster pixel
// block in, one scaled and saturated coefficient out; basis built from a shared 1D ROM.
module dct_coef_engine #(
   parameter  int N     = 8,
   parameter  int PIX_W = 9,
   parameter  int CF    = 15,
   parameter  int FRAC  = 10,
   parameter  int ACC_W = 32,
   parameter  int OUT_W = 16,
   localparam int IW    = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_valid,
   output logic                    start_ready,
   input  logic [IW-1:0]           k1,
   input  logic [IW-1:0]           k2,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   input  logic signed [PIX_W-1:0] pix,
   input  logic                    clear,
   output logic                    coef_valid,
   input  logic                    coef_ready,
   output logic signed [OUT_W-1:0] coef,
   output logic                    busy
);

   localparam int CW  = CF + 2;
   localparam int T_W = FRAC + 2;
   localparam int SH  = 2 * CF - FRAC;
   localparam int P_W = PIX_W + T_W;
   localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam real PI = 3.14159265358979323846;

   // Rounded half away from zero; evaluated only at elaboration.
   function automatic int rom_val(input int k, input int n);
      real a;
      real x;
      a = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
      x = (2.0 ** CF) * a * $cos((2.0 * n + 1.0) * k * PI / (2.0 * N));
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [IW-1:0]            r_k1, r_k2, r_n1, r_n2;
   logic signed [PIX_W-1:0]  r_pix;
   logic signed [T_W-1:0]    r_t;
   logic                     r_s1_valid;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_drain;
   logic signed [OUT_W-1:0]  r_coef;
   logic signed [CW-1:0]     w_rom [N][N];
   logic signed [2*CW-1:0]   w_full;
   logic signed [P_W-1:0]    w_prod;
   logic signed [ACC_W-1:0]  w_shift;
   logic signed [OUT_W-1:0]  w_sat;
   logic                     w_start_hs, w_pix_hs, w_coef_hs, w_last;

   for (genvar gk = 0; gk < N; gk++) begin : g_rom_k
      for (genvar gn = 0; gn < N; gn++) begin : g_rom_n
         localparam logic signed [CW-1:0] C_VAL = CW'(rom_val(gk, gn));
         assign w_rom[gk][gn] = C_VAL;
      end
   end

   assign start_ready = (r_state == S_IDLE);
   assign pix_ready   = (r_state == S_ACCUM);
   assign coef_valid  = (r_state == S_DONE);
   assign busy        = (r_state != S_IDLE);
   assign coef        = r_coef;

   // clear masks every handshake so nothing is consumed in its cycle
   assign w_start_hs = start_valid & start_ready & ~clear;
   assign w_pix_hs   = pix_valid & pix_ready & ~clear;
   assign w_coef_hs  = coef_valid & coef_ready & ~clear;
   assign w_last     = w_pix_hs & (r_n1 == IDX_MAX) & (r_n2 == IDX_MAX);

   assign w_full  = w_rom[r_k1][r_n1] * w_rom[r_k2][r_n2];
   assign w_prod  = r_pix * r_t;
   assign w_shift = r_acc >>> FRAC;

   always_comb begin
      w_sat = w_shift[OUT_W-1:0];
      if (w_shift > SAT_MAX)      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
      else if (w_shift < SAT_MIN) w_sat = {1'b1, {(OUT_W-1){1'b0}}};
   end

   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_start_hs) w_next = S_ACCUM;
            S_ACCUM: if (w_last)     w_next = S_DRAIN;
            S_DRAIN: if (r_drain)    w_next = S_DONE;
            S_DONE:  if (w_coef_hs)  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Stage 1 captures pixel and basis term; stage 2 accumulates one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k1       <= '0;
         r_k2       <= '0;
         r_n1       <= '0;
         r_n2       <= '0;
         r_pix      <= '0;
         r_t        <= '0;
         r_s1_valid <= 1'b0;
         r_acc      <= '0;
         r_drain    <= 1'b0;
         r_coef     <= '0;
      end else if (clear) begin
         r_n1       <= '0;
         r_n2       <= '0;
         r_s1_valid <= 1'b0;
         r_acc      <= '0;
         r_drain    <= 1'b0;
      end else begin
         if (w_start_hs) begin
            r_k1  <= k1;
            r_k2  <= k2;
            r_n1  <= '0;
            r_n2  <= '0;
            r_acc <= '0;
         end
         r_s1_valid <= w_pix_hs;
         if (w_pix_hs) begin
            r_pix <= pix;
            r_t   <= T_W'(w_full >>> SH);
            r_n2  <= r_n2 + IW'(1);
            if (r_n2 == IDX_MAX) r_n1 <= r_n1 + IW'(1);
         end
         if (r_s1_valid) r_acc <= r_acc + ACC_W'(w_prod);
         r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
         if ((r_state == S_DRAIN) && r_drain) r_coef <= w_sat;
      end
   end

endmodule

// File: tb/tb_dct_coef_engine.sv
// Bench for dct_coef_engine: a 16-bit and an 8-bit-output instance share stimulus;
// expected coefficients are queued per instance and checked by negedge monitors.
module tb_dct_coef_engine;

   localparam int N = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_valid;
   logic [2:0]        k1, k2;
   logic              pix_valid;
   logic signed [8:0] pix;
   logic              clear;
   logic              coef_ready;

   logic               start_ready, pix_ready, coef_valid, busy;
   logic signed [15:0] coef;
   logic               s_start_ready, s_pix_ready, s_coef_valid, s_busy;
   logic signed [7:0]  s_coef;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_hs  = 0;
   int pix_mem [N*N];

   logic [15:0] exp_q[$];
   logic [7:0]  exp_s_q[$];

   logic               prev_valid, prev_stall;
   logic signed [15:0] held;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dct_coef_engine u_dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .k1(k1), .k2(k2), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix(pix),
      .clear(clear), .coef_valid(coef_valid), .coef_ready(coef_ready), .coef(coef),
      .busy(busy)
   );

   dct_coef_engine #(.OUT_W(8)) u_sat (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(s_start_ready),
      .k1(k1), .k2(k2), .pix_valid(pix_valid), .pix_ready(s_pix_ready), .pix(pix),
      .clear(clear), .coef_valid(s_coef_valid), .coef_ready(coef_ready), .coef(s_coef),
      .busy(s_busy)
   );

   function automatic void check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
         prev_stall <= 1'b0;
      end else begin
         if (coef_valid) begin
            if (prev_stall) check("coef_stable", coef, held);
            // last_hs is taken just after the handshake edge, i.e. one cycle into the count
            if (!prev_valid) check("latency", cyc - (last_hs - 1), 3);
            if (coef_ready) begin
               if (exp_q.size() == 0) check("unexpected_coef", 1, 0);
               else                   check("coef", coef, $signed(exp_q.pop_front()));
            end
         end
         prev_valid <= coef_valid;
         prev_stall <= coef_valid && !coef_ready;
         held       <= coef;
      end
   end

   always @(negedge clk) begin
      if (rst_n && s_coef_valid && coef_ready) begin
         if (exp_s_q.size() == 0) check("unexpected_sat_coef", 1, 0);
         else                     check("sat_coef", s_coef, $signed(exp_s_q.pop_front()));
      end
   end

   // ---------------- drivers ----------------
   task automatic push_exp(input int e16, input int e8);
      exp_q.push_back(16'(e16));
      exp_s_q.push_back(8'(e8));
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < N*N; i++) pix_mem[i] = v;
   endtask

   task automatic start_req(input int a, input int b);
      int t;
      t = 0;
      start_valid = 1'b1;
      k1 = 3'(a);
      k2 = 3'(b);
      while (!start_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) check("start_timeout", 0, 1);
      @(posedge clk); #1;
      start_valid = 1'b0;
   endtask

   task automatic send_block(input int npix, input bit gaps);
      int t;
      for (int i = 0; i < npix; i++) begin
         if (gaps) begin pix_valid = 1'b0; @(posedge clk); #1; end
         pix_valid = 1'b1;
         pix = 9'(pix_mem[i]);
         t = 0;
         while (!pix_ready && t < 100) begin @(posedge clk); #1; t++; end
         if (t >= 100) check("pix_timeout", 0, 1);
         @(posedge clk); #1;
         last_hs = cyc;
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || s_busy) && t < 300) begin @(posedge clk); #1; t++; end
      if (t >= 300) check("idle_timeout", 0, 1);
   endtask

   task automatic run_case(input int a, input int b, input int e16, input int e8);
      push_exp(e16, e8);
      start_req(a, b);
      send_block(N*N, 1'b0);
      wait_idle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start_ready"}, start_ready, 1);
      check({tag, "_pix_ready"},   pix_ready, 0);
      check({tag, "_coef_valid"},  coef_valid, 0);
      check({tag, "_coef"},        coef, 0);
      check({tag, "_busy"},        busy, 0);
      check({tag, "_sat_busy"},    {s_busy, s_coef_valid, s_pix_ready, s_start_ready}, 4'b0001);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t;
      rst_n = 1'b0; start_valid = 1'b0; k1 = '0; k2 = '0;
      pix_valid = 1'b0; pix = '0; clear = 1'b0; coef_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // DC flat block: t=127, acc=812800 -> 793; 8-bit clamps to 127
      fill(100);
      run_case(0, 0, 793, 127);

      // positive impulse at (0,0), k=(2,3): t=196, acc=49980 -> 48
      fill(0); pix_mem[0] = 255;
      run_case(2, 3, 48, 48);

      // impulse at (0,1): t=floor(-46.1)=-47, acc=-11985 -> floor -11.7 = -12
      fill(0); pix_mem[1] = 255;
      run_case(2, 3, -12, -12);

      // gaps on pix_valid, result stalled 5 cycles with start_valid pushed in DONE
      fill(100);
      push_exp(793, 127);
      coef_ready = 1'b0;
      start_req(0, 0);
      send_block(N*N, 1'b1);
      t = 0;
      while (!coef_valid && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) check("valid_timeout", 0, 1);
      for (int i = 0; i < 5; i++) begin
         start_valid = 1'b1;
         check("start_ready_in_done", start_ready, 0);
         check("valid_held", coef_valid, 1);
         @(posedge clk); #1;
      end
      start_valid = 1'b0;
      coef_ready = 1'b1;
      wait_idle();

      // all -256: acc=-2080768 -> -2032; 8-bit clamps to -128
      fill(-256);
      run_case(0, 0, -2032, -128);

      // clear after 30 pixels; the pixel offered with clear is not consumed
      fill(100);
      start_req(0, 0);
      send_block(30, 1'b0);
      clear = 1'b1; pix_valid = 1'b1; pix = 9'sd100;
      @(posedge clk); #1;
      clear = 1'b0; pix_valid = 1'b0;
      check("clear_busy", busy, 0);
      check("clear_start_ready", start_ready, 1);
      run_case(0, 0, 793, 127);

      // asynchronous reset mid-block, away from any clock edge
      start_req(0, 0);
      send_block(20, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_case(0, 0, 793, 127);

      repeat (4) @(posedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      check("exp_s_q_drained", exp_s_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dct_coef_engine.md
Name: dct_coef_engine

Overview:
- Sequential, parametrised 2D DCT coefficient engine.
- Accepts one (k1,k2) request, then consumes an NxN pixel block in raster order (n1 outer, n2 inner) over a valid/ready stream.
- Multiply-accumulates each pixel against the separable cosine basis term and returns one scaled, saturated coefficient over a valid/ready handshake.
- Replaces the per-(k1,k2) fixed combinational basis tables in the DCT datapath with one generated 1D ROM shared across all frequencies.

Parameters:
- N, 8: block edge; power of 2, 4..16.
- PIX_W, 9: signed pixel width.
- CF, 15: fraction bits of 1D cosine ROM entries.
- FRAC, 10: fraction bits of the 2D basis term; must satisfy FRAC < 2*CF.
- ACC_W, 32: signed accumulator width.
- OUT_W, 16: signed coefficient output width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request valid.
- start_ready  out  1  engine can accept a request.
- k1  in  log2(N)  row frequency; sampled on start handshake.
- k2  in  log2(N)  column frequency; sampled on start handshake.
- pix_valid  in  1  pixel valid.
- pix_ready  out  1  engine accepts a pixel.
- pix  in  PIX_W  signed pixel.
- clear  in  1  synchronous abort.
- coef_valid  out  1  result valid.
- coef_ready  in  1  downstream accepts result.
- coef  out  OUT_W  signed coefficient.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, start_ready=1, pix_ready=0, coef_valid=0, coef=0, busy=0, counters=0, accumulator=0.
- 1D ROM, elaboration-time constant:
  - c[k][n] = round(2^CF * a(k) * cos((2n+1)kπ/(2N))).
  - a(0) = sqrt(1/N); a(k>0) = sqrt(2/N).
  - Entries are CF+2 bits signed.
- Basis term: t = (c[k1][n1] * c[k2][n2]) >>> (2*CF-FRAC). The shift is arithmetic (floor toward -inf).
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: latch k1/k2, zero the accumulator and n1/n2, go to ACCUM.
- ACCUM:
  - pix_ready=1. A pixel is accepted on pix_valid&pix_ready.
  - Stage 1 registers pix and t(n1,n2).
  - Stage 2 adds pix*t into the accumulator; wraps at ACC_W bits with no saturation.
  - n2 increments per accepted pixel and wraps to 0 at N-1, incrementing n1.
  - After the N*N-th accepted pixel, pix_ready drops the next cycle and the state goes to DRAIN.
  - Gaps in pix_valid stall the counters; the pipeline continues draining.
- DRAIN: 2 cycles, then DONE.
- Latency: coef_valid rises exactly 3 cycles after the last pixel handshake.
- DONE:
  - coef_valid=1.
  - coef = saturate_OUT_W(acc >>> FRAC), floor shift; clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - coef stays stable while coef_valid&!coef_ready.
  - On coef_ready, go to IDLE the next cycle.
  - start_ready=0 in DONE; no request overlap.
- clear:
  - Effective in any state; wins over every simultaneous handshake.
  - Next state is IDLE, with the accumulator and counters zeroed and coef_valid=0.
  - A pixel or result presented in the same cycle is not consumed.
- Out-of-phase handshakes: start_valid outside IDLE and pix_valid outside ACCUM are ignored; no state change.
- Reset mid-operation: immediate return to reset values; a partial block is discarded.

Test Plan:
- DC, flat block: reset, k1=0,k2=0, 64 pixels of 100 with pix_valid held high.
  - c[0][n]=11585; t=127.
  - acc=812800; coef=793.
  - coef_valid exactly 3 cycles after the 64th handshake.
- Positive impulse: k1=2,k2=3, pix(0,0)=255, all others 0.
  - c[2][0]=15137, c[3][0]=13623; t=196.
  - acc=49980; coef=48.
- Negative term with floor rounding: k1=2,k2=3, pix(0,1)=255, all others 0.
  - c[3][1]=-3196; t=-47.
  - acc=-11985; coef=-12.
- Backpressure and gaps: DC case with pix_valid toggling every other cycle and coef_ready held low 5 cycles.
  - Result still 793, stable throughout the stall.
  - start_valid asserted during DONE is not accepted.
- Saturation: OUT_W=8, DC case: coef clamps to 127. All pixels -256: coef clamps to -128.
- Abort and reset: clear after 30 pixels, then a new DC request with 64 pixels of 100 → 793 (no residue). Repeat with rst_n pulsed low mid-block → all outputs at reset values asynchronously.
